// File: rtl/traffic_light_controller.sv
// Fixed-time two-way intersection sequencer: NS green/yellow/all-red, then EW green/yellow/all-red.
// Moore FSM with a tick prescaler and per-phase dwell counter; lamp drives are registered.
module traffic_light_controller #(
    parameter int unsigned GREEN_TICKS  = 5,
    parameter int unsigned YELLOW_TICKS = 1,
    parameter int unsigned ALLRED_TICKS = 1,
    parameter int unsigned TICK_DIV     = 1
) (
    input  logic       clk,
    input  logic       clr,
    output logic [5:0] lights
);

    localparam int unsigned MAX_GY    = (GREEN_TICKS > YELLOW_TICKS) ? GREEN_TICKS : YELLOW_TICKS;
    localparam int unsigned MAX_DWELL = (MAX_GY > ALLRED_TICKS) ? MAX_GY : ALLRED_TICKS;
    localparam int unsigned CW        = (MAX_DWELL > 1) ? $clog2(MAX_DWELL) : 1;
    localparam int unsigned PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [5:0] L_NS_GREEN  = 6'b001100;
    localparam logic [5:0] L_NS_YELLOW = 6'b010100;
    localparam logic [5:0] L_ALL_RED   = 6'b100100;
    localparam logic [5:0] L_EW_GREEN  = 6'b100001;
    localparam logic [5:0] L_EW_YELLOW = 6'b100010;

    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4,
        S5 = 3'd5
    } state_t;

    // Raw state bits are kept so an unused code can be decoded and recovered from.
    logic [2:0]    state_q;
    state_t        state;
    state_t        state_d;
    state_t        state_nxt;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [PW-1:0] pre_q;
    logic [1:0]    sync_q;
    logic          run;
    logic          tick;
    logic          illegal;
    int unsigned   dwell;
    logic [5:0]    lights_d;

    assign state = state_t'(state_q);

    // Release synchroniser: counting is enabled once the second flop has seen clr high.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], 1'b1};
        end
    end

    assign run  = sync_q[1];
    assign tick = run && (pre_q == PW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            pre_q <= '0;
        end else if (run) begin
            pre_q <= tick ? '0 : pre_q + PW'(1);
        end
    end

    function automatic logic [5:0] decode(input state_t s);
        logic [5:0] l;
        l = L_ALL_RED;
        case (s)
            S0:      l = L_NS_GREEN;
            S1:      l = L_NS_YELLOW;
            S2:      l = L_ALL_RED;
            S3:      l = L_EW_GREEN;
            S4:      l = L_EW_YELLOW;
            S5:      l = L_ALL_RED;
            default: l = L_ALL_RED;
        endcase
        return l;
    endfunction

    // Next-state, dwell counter and lamp decode.
    always_comb begin
        state_d   = state;
        cnt_d     = cnt_q;
        state_nxt = S0;
        dwell     = GREEN_TICKS;
        illegal   = 1'b0;
        case (state)
            S0:      begin dwell = GREEN_TICKS;  state_nxt = S1; end
            S1:      begin dwell = YELLOW_TICKS; state_nxt = S2; end
            S2:      begin dwell = ALLRED_TICKS; state_nxt = S3; end
            S3:      begin dwell = GREEN_TICKS;  state_nxt = S4; end
            S4:      begin dwell = YELLOW_TICKS; state_nxt = S5; end
            S5:      begin dwell = ALLRED_TICKS; state_nxt = S0; end
            default: illegal = 1'b1;
        endcase
        if (illegal) begin
            state_d = S2;
            cnt_d   = '0;
        end else if (tick) begin
            if (cnt_q == CW'(dwell - 1)) begin
                state_d = state_nxt;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        lights_d = decode(state_d);
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= 3'(S0);
            cnt_q   <= '0;
            lights  <= L_NS_GREEN;
        end else begin
            state_q <= 3'(state_d);
            cnt_q   <= cnt_d;
            lights  <= lights_d;
        end
    end

endmodule

// File: tb/tb_traffic_light_controller.sv
// Directed bench for traffic_light_controller: segment tables of expected lamp values per
// clock, plus async reset, illegal-state recovery and a randomized-reset safety monitor.
module tb_traffic_light_controller;

    typedef struct {
        logic [5:0] exp;
        int         n;
    } seg_t;

    logic       clk = 1'b0;
    logic       clr_a;
    logic       clr_b;
    logic [5:0] lights_a;
    logic [5:0] lights_b;

    int   total = 0;
    int   bad   = 0;
    seg_t segs[16];
    int   nseg;

    traffic_light_controller dut_a (
        .clk    (clk),
        .clr    (clr_a),
        .lights (lights_a)
    );

    traffic_light_controller #(
        .GREEN_TICKS  (2),
        .YELLOW_TICKS (1),
        .ALLRED_TICKS (1),
        .TICK_DIV     (3)
    ) dut_b (
        .clk    (clk),
        .clr    (clr_b),
        .lights (lights_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: lights=%b expected %b", name, act, exp);
        end
    endtask

    function automatic bit safe(input logic [5:0] l);
        bit ok;
        ok = $onehot(l[5:3]) && $onehot(l[2:0]);
        ok = ok && !(l[3] && l[0]);
        ok = ok && !((l[3] || l[4]) && (l[0] || l[1]));
        return ok;
    endfunction

    task automatic add_seg(input logic [5:0] exp, input int n);
        segs[nseg].exp = exp;
        segs[nseg].n   = n;
        nseg++;
    endtask

    // Expected lamps after each edge following release of clr at a falling edge.
    task automatic load_default();
        nseg = 0;
        add_seg(6'b001100, 6);
        add_seg(6'b010100, 1);
        add_seg(6'b100100, 1);
        add_seg(6'b100001, 5);
        add_seg(6'b100010, 1);
        add_seg(6'b100100, 1);
        add_seg(6'b001100, 5);
        add_seg(6'b010100, 1);
        add_seg(6'b100100, 1);
    endtask

    task automatic run_segs(input string tag, input bit use_b);
        int e;
        e = 0;
        for (int s = 0; s < nseg; s++) begin
            for (int k = 0; k < segs[s].n; k++) begin
                @(posedge clk);
                #1;
                e++;
                chk($sformatf("%s_edge%0d", tag, e), use_b ? lights_b : lights_a, segs[s].exp);
            end
        end
    endtask

    initial begin
        clr_a = 1'b1;
        clr_b = 1'b1;
        #1;
        clr_a = 1'b0;
        clr_b = 1'b0;
        #1;
        chk("reset_a_noclk", lights_a, 6'b001100);
        chk("reset_b_noclk", lights_b, 6'b001100);
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("reset_a_held", lights_a, 6'b001100);
        end

        // Default sequence from release.
        @(negedge clk);
        clr_a = 1'b1;
        load_default();
        run_segs("dflt", 1'b0);

        // Async reset between edges while EW is green.
        @(posedge clk);
        #1;
        chk("pre_reset_s3", lights_a, 6'b100001);
        #2;
        clr_a = 1'b0;
        #1;
        chk("async_reset", lights_a, 6'b001100);
        @(negedge clk);
        clr_a = 1'b1;
        run_segs("after_rst", 1'b0);

        // Illegal state code forced mid-green recovers through all-red.
        @(negedge clk);
        clr_a = 1'b0;
        @(negedge clk);
        clr_a = 1'b1;
        nseg = 0;
        add_seg(6'b001100, 3);
        run_segs("pre_illegal", 1'b0);
        @(negedge clk);
        force dut_a.state_q = 3'b111;
        #1;
        release dut_a.state_q;
        nseg = 0;
        add_seg(6'b100100, 1);
        add_seg(6'b100001, 5);
        add_seg(6'b100010, 1);
        add_seg(6'b100100, 1);
        add_seg(6'b001100, 5);
        add_seg(6'b010100, 1);
        run_segs("illegal", 1'b0);

        // Prescaled instance: GREEN=2, YELLOW=1, ALLRED=1, TICK_DIV=3.
        @(negedge clk);
        clr_b = 1'b1;
        nseg = 0;
        add_seg(6'b001100, 7);
        add_seg(6'b010100, 3);
        add_seg(6'b100100, 3);
        add_seg(6'b100001, 6);
        add_seg(6'b100010, 3);
        add_seg(6'b100100, 3);
        add_seg(6'b001100, 6);
        add_seg(6'b010100, 1);
        run_segs("presc", 1'b1);

        // Safety monitor with random reset pulses on the default instance.
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            clr_a = ($urandom_range(0, 39) != 0);
            #2;
            total++;
            if (!safe(lights_a)) begin
                bad++;
                $display("FAIL safety_a cyc%0d: lights=%b expected a safe pattern", c, lights_a);
            end
            @(posedge clk);
            #1;
            total++;
            if (!safe(lights_a) || !safe(lights_b)) begin
                bad++;
                $display("FAIL safety cyc%0d: lights_a=%b lights_b=%b expected safe patterns",
                         c, lights_a, lights_b);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
